// File: rtl/alu8_pkg.sv
// rtl/alu8_pkg.sv - shared widths, opcode tags, result-stage states and flag struct
package alu8_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } rs_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } alu_flags_t;

endpackage

// File: rtl/alu8_result_stage_if.sv
// rtl/alu8_result_stage_if.sv - input/output handshake bundle of the ALU result stage
interface alu8_result_stage_if
    import alu8_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [OP_W-1:0]   out_op;
    logic              out_zero;
    logic              out_neg;
    logic              out_parity;

    // Environment side: upstream producer plus downstream consumer.
    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity
    );

    // Result stage side.
    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity
    );

endinterface

// File: rtl/alu8_flag_gen.sv
// rtl/alu8_flag_gen.sv - combinational status flags for an 8-bit result (parity under ALU_PARITY_EN)
module alu8_flag_gen
    import alu8_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] result_i,
    output alu_flags_t            flags_o
);

    // Zero/negative always; parity only when the feature is built in.
    always_comb begin
        flags_o.zero = (result_i == '0);
        flags_o.neg  = result_i[ALU_DATA_W-1];
`ifdef ALU_PARITY_EN
        flags_o.parity = ^result_i;
`else
        flags_o.parity = 1'b0;
`endif
    end

endmodule

// File: rtl/alu8_result_stage.sv
// rtl/alu8_result_stage.sv - registered ALU result stage with 2-entry skid buffer (parity under ALU_PARITY_EN)
module alu8_result_stage
    import alu8_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic                clk,
    input  logic                rst,
    alu8_result_stage_if.slave  bus,
    output logic [7:0]          result_count
);

    rs_state_t         state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_result_q;
    logic [OP_W-1:0]   main_op_q;
    logic              zero_q, neg_q;
    logic [DATA_W-1:0] skid_result_q;
    logic [OP_W-1:0]   skid_op_q;
    logic [7:0]        count_q;

    logic              in_hs, out_hs;
    logic              load_main, load_skid, main_from_skid;
    logic [DATA_W-1:0] load_result;
    logic [OP_W-1:0]   load_op;
    alu_flags_t        load_flags;

    assign in_hs  = bus.in_valid && in_ready_q;
    assign out_hs = (state_q != EMPTY) && bus.out_ready;

    // Main is refilled either from the skid (draining FULL) or straight from the input.
    assign load_result = main_from_skid ? skid_result_q : bus.in_result;
    assign load_op     = main_from_skid ? skid_op_q     : bus.in_op;

    alu8_flag_gen u_flag_gen (
        .result_i (load_result),
        .flags_o  (load_flags)
    );

    // Next-state and load controls for the EMPTY/ONE/FULL occupancy machine.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_main = 1'b1;
                end else if (in_hs) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, storage entries, registered in_ready and the delivered-result counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            in_ready_q    <= 1'b1;
            main_result_q <= '0;
            main_op_q     <= '0;
            zero_q        <= 1'b0;
            neg_q         <= 1'b0;
            skid_result_q <= '0;
            skid_op_q     <= '0;
            count_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (load_main) begin
                main_result_q <= load_result;
                main_op_q     <= load_op;
                zero_q        <= load_flags.zero;
                neg_q         <= load_flags.neg;
            end
            if (load_skid) begin
                skid_result_q <= bus.in_result;
                skid_op_q     <= bus.in_op;
            end
            if (out_hs) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

`ifdef ALU_PARITY_EN
    logic parity_q;

    // Parity is captured together with the result so it never lags out_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load_main) begin
            parity_q <= load_flags.parity;
        end
    end

    assign bus.out_parity = parity_q;
`else
    logic unused_parity;
    assign unused_parity  = load_flags.parity;
    assign bus.out_parity = 1'b0;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state_q != EMPTY);
    assign bus.out_result = main_result_q;
    assign bus.out_op     = main_op_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_neg    = neg_q;
    assign result_count   = count_q;

endmodule

// File: tb/tb_alu8_result_stage.sv
// tb/tb_alu8_result_stage.sv - scoreboard bench for alu8_result_stage
module tb_alu8_result_stage;

`ifdef ALU_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] result_count;

    always #5 clk = ~clk;

    alu8_result_stage_if bus ();

    alu8_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .result_count (result_count)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [2:0] op;
        logic       zero;
        logic       neg;
        logic       par;
    } exp_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   exp_count = 0;
    bit   stalled   = 1'b0;
    exp_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one input and record its expected output when the input handshake is seen.
    task automatic send(input logic [7:0] r, input logic [2:0] op,
                        input logic z, input logic n, input logic p);
        bus.in_valid  = 1'b1;
        bus.in_result = r;
        bus.in_op     = op;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{res: r, op: op, zero: z, neg: n, par: (PAR_EN ? p : 1'b0)});
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 expected accept of %0h", r);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 64; t++) begin
            if (sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks the counter and hold rules.
    always @(negedge clk) begin
        if (rst) begin
            exp_count = 0;
            stalled   = 1'b0;
        end else begin
            check("result_count", {24'd0, result_count}, exp_count[7:0]);
            if (stalled) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_result", bus.out_result, held.res);
                check("hold_op", bus.out_op, held.op);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h expected no output", bus.out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_result", bus.out_result, e.res);
                    check("out_op", bus.out_op, e.op);
                    check("out_zero", bus.out_zero, e.zero);
                    check("out_neg", bus.out_neg, e.neg);
                    check("out_parity", bus.out_parity, e.par);
                end
                exp_count++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = '{res: bus.out_result, op: bus.out_op, zero: 1'b0, neg: 1'b0, par: 1'b0};
        end
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = 8'h00;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_op", bus.out_op, 0);
        check("rst_out_zero", bus.out_zero, 0);
        check("rst_out_neg", bus.out_neg, 0);
        check("rst_out_parity", bus.out_parity, 0);
        check("rst_count", result_count, 0);
        @(posedge clk);
        #1;

        // One-cycle latency with a zero result.
        bus.out_ready = 1'b1;
        send(8'h00, 3'd2, 1'b1, 1'b0, 1'b0);
        check("lat_valid", bus.out_valid, 1);
        check("lat_result", bus.out_result, 8'h00);
        check("lat_zero", bus.out_zero, 1);
        check("lat_op", bus.out_op, 2);

        // Back-to-back stream at full rate.
        send(8'hFF, 3'd3, 1'b0, 1'b1, 1'b0);
        send(8'h80, 3'd4, 1'b0, 1'b1, 1'b1);
        send(8'h01, 3'd5, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-pressure: fill main and skid, third input must stall.
        bus.out_ready = 1'b0;
        send(8'hA5, 3'd0, 1'b0, 1'b1, 1'b0);
        send(8'h5A, 3'd1, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", bus.in_ready, 0);
        check("full_main", bus.out_result, 8'hA5);
        fork
            send(8'h3C, 3'd6, 1'b0, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_main", bus.out_result, 8'hA5);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("no_dup", sb.size(), 0);

        // Counter wrap after 257 deliveries.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] v;
            v = i[7:0];
            send(v, i[2:0], (v == 8'h00), v[7], ^v);
        end
        drain();
        check("count_wrap", result_count, 8'd1);

        // Reset while FULL discards both entries.
        bus.out_ready = 1'b0;
        send(8'h11, 3'd1, 1'b0, 1'b0, 1'b0);
        send(8'h22, 3'd2, 1'b0, 1'b0, 1'b0);
        check("pre_rst_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("post_rst_valid", bus.out_valid, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_count", result_count, 0);
        bus.out_ready = 1'b1;
        send(8'h77, 3'd7, 1'b0, 1'b0, 1'b0);
        check("alone_result", bus.out_result, 8'h77);
        @(posedge clk);
        #1;
        check("alone_valid", bus.out_valid, 0);
        check("alone_count", result_count, 8'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
